ising_core_reg_ctrl: RTL

Register-interface front end of each Ising core wrapper. It is the direct downstream consumer of one SoC external register-bus slave port (`reg_ext_req[i]`/`reg_ext_rsp[i]`). It decodes CPU register accesses into configuration and control state and runs the start/iterate/done/timeout sequence toward the Ising core datapath. It also raises a per-core interrupt.

---
 rtl/ising_core_reg_ctrl.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ising_core_reg_ctrl.sv
// ---------------------------------------------------------------------------
// ising_core_reg_ctrl
//
// Register-bus front end of one Ising core wrapper. It decodes CPU accesses
// into configuration/control state and sequences the core datapath through
// start -> iterate -> done (or timeout / soft abort). It also raises a
// level interrupt when a run ends.
//
// Ports
//   clk_i, rst_ni        core clock, asynchronous active-low reset
//   reg_valid_i          request valid (accepted the same cycle)
//   reg_write_i          1 = write, 0 = read
//   reg_addr_i           byte address, only bits [4:2] are decoded
//   reg_wdata_i          write data
//   reg_wstrb_i          byte strobes
//   reg_rdata_o          read data (combinational, 0 on error or write)
//   reg_error_o          access error (combinational)
//   reg_ready_o          request accepted (= reg_valid_i)
//   core_start_o         one-cycle start pulse to the datapath
//   core_abort_o         one-cycle abort pulse to the datapath
//   core_num_iter_o      iteration target latched at start
//   core_iter_done_i     one-cycle pulse per completed iteration
//   busy_o               sequencer not idle
//   irq_o                registered level interrupt
//
// Register map (word offsets)
//   0x00 CTRL        [0] START (pulse) [1] SOFT_RST (pulse) [2] IRQ_EN
//   0x04 STATUS      [0] BUSY (RO) [1] DONE (W1C) [2] TIMEOUT (W1C)
//   0x08 NUM_ITER    R/W, IterWidth bits
//   0x0C TIMEOUT_CYC R/W, 0 disables the timeout
//   0x10 CYCLE_CNT   RO
//   0x14 ITER_CNT    RO
//
// Sequencer states
//   state  | meaning
//   IDLE   | waiting for START, datapath quiet
//   RUN    | datapath iterating, cycle/iteration counters advancing
//   FINISH | final iteration seen, DONE set, back to IDLE next cycle
// ---------------------------------------------------------------------------
module ising_core_reg_ctrl #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IterWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic                   reg_ready_o,
  output logic                   core_start_o,
  output logic                   core_abort_o,
  output logic [IterWidth-1:0]   core_num_iter_o,
  input  logic                   core_iter_done_i,
  output logic                   busy_o,
  output logic                   irq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [2:0] AddrCtrl    = 3'd0;
  localparam logic [2:0] AddrStatus  = 3'd1;
  localparam logic [2:0] AddrNumIter = 3'd2;
  localparam logic [2:0] AddrTimeout = 3'd3;
  localparam logic [2:0] AddrCycle   = 3'd4;
  localparam logic [2:0] AddrIter    = 3'd5;

  localparam logic [IterWidth-1:0] IterOne = IterWidth'(1);
  localparam logic [DataWidth-1:0] CycOne  = DataWidth'(1);

  state_e                 state_q, state_d;
  logic                   irq_en_q, irq_en_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [IterWidth-1:0]   num_iter_q, num_iter_d;
  logic [DataWidth-1:0]   timeout_cyc_q, timeout_cyc_d;
  logic [DataWidth-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [IterWidth-1:0]   iter_cnt_q, iter_cnt_d;
  logic [IterWidth-1:0]   core_num_iter_q, core_num_iter_d;
  logic                   start_q, start_d;
  logic                   abort_q, abort_d;
  logic                   irq_q, irq_d;

  // Only bits [4:2] select a register; the rest are don't-care.
  logic                   unused_addr;
  assign unused_addr = ^{reg_addr_i[AddrWidth-1:5], reg_addr_i[1:0]};

  logic [2:0] word_sel;
  logic       busy;
  logic       wr_req, rd_req;
  logic       sel_ctrl, sel_status, sel_num, sel_tmo, sel_ro, sel_unmapped;
  logic       soft_rst_req, start_req;
  logic       acc_err, wr_ok, start_ok, soft_rst_ok;
  logic [IterWidth-1:0] iter_next;
  logic       iter_complete, tmo_hit;
  logic [DataWidth-1:0] rdata_rd;

  assign word_sel     = reg_addr_i[4:2];
  assign busy         = (state_q != IDLE);
  assign wr_req       = reg_valid_i & reg_write_i;
  assign rd_req       = reg_valid_i & ~reg_write_i;

  assign sel_ctrl     = (word_sel == AddrCtrl);
  assign sel_status   = (word_sel == AddrStatus);
  assign sel_num      = (word_sel == AddrNumIter);
  assign sel_tmo      = (word_sel == AddrTimeout);
  assign sel_ro       = (word_sel == AddrCycle) | (word_sel == AddrIter);
  assign sel_unmapped = (word_sel > AddrIter);

  // SOFT_RST masks START when both are written together, so that combination
  // can never raise a START error.
  assign soft_rst_req = wr_req & sel_ctrl & reg_wstrb_i[0] & reg_wdata_i[1];
  assign start_req    = wr_req & sel_ctrl & reg_wstrb_i[0] & reg_wdata_i[0] & ~reg_wdata_i[1];

  assign acc_err = (reg_valid_i & sel_unmapped)
                 | (wr_req & sel_ro)
                 | (wr_req & (sel_num | sel_tmo) & busy)
                 | (start_req & (busy | (num_iter_q == '0)));

  assign wr_ok       = wr_req & ~acc_err;
  assign start_ok    = start_req & ~acc_err;
  assign soft_rst_ok = soft_rst_req & ~acc_err;

  assign iter_next     = iter_cnt_q + IterOne;
  assign iter_complete = core_iter_done_i & (iter_next == core_num_iter_q);
  assign tmo_hit       = (timeout_cyc_q != '0) & (cycle_cnt_q == timeout_cyc_q - CycOne);

  always_comb begin
    rdata_rd = '0;
    case (word_sel)
      AddrCtrl:    rdata_rd[2]             = irq_en_q;
      AddrStatus:  rdata_rd[2:0]           = {timeout_q, done_q, busy};
      AddrNumIter: rdata_rd[IterWidth-1:0] = num_iter_q;
      AddrTimeout: rdata_rd                = timeout_cyc_q;
      AddrCycle:   rdata_rd                = cycle_cnt_q;
      AddrIter:    rdata_rd[IterWidth-1:0] = iter_cnt_q;
      default:     rdata_rd                = '0;
    endcase
  end

  assign reg_ready_o = reg_valid_i;
  assign reg_error_o = acc_err;
  assign reg_rdata_o = (rd_req & ~acc_err) ? rdata_rd : '0;

  always_comb begin
    state_d         = state_q;
    irq_en_d        = irq_en_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    num_iter_d      = num_iter_q;
    timeout_cyc_d   = timeout_cyc_q;
    cycle_cnt_d     = cycle_cnt_q;
    iter_cnt_d      = iter_cnt_q;
    core_num_iter_d = core_num_iter_q;
    start_d         = 1'b0;
    abort_d         = 1'b0;

    // Register-side updates; the sequencer below may override the flags so
    // that a hardware set wins over a same-cycle W1C.
    if (wr_ok && sel_ctrl && reg_wstrb_i[0]) begin
      irq_en_d = reg_wdata_i[2];
    end
    if (wr_ok && sel_num) begin
      for (int i = 0; i < int'(IterWidth); i++) begin
        if (reg_wstrb_i[i/8]) num_iter_d[i] = reg_wdata_i[i];
      end
    end
    if (wr_ok && sel_tmo) begin
      for (int i = 0; i < int'(DataWidth); i++) begin
        if (reg_wstrb_i[i/8]) timeout_cyc_d[i] = reg_wdata_i[i];
      end
    end
    if (wr_ok && sel_status && reg_wstrb_i[0]) begin
      if (reg_wdata_i[1]) done_d    = 1'b0;
      if (reg_wdata_i[2]) timeout_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d         = RUN;
          start_d         = 1'b1;
          core_num_iter_d = num_iter_q;
          cycle_cnt_d     = '0;
          iter_cnt_d      = '0;
          done_d          = 1'b0;
          timeout_d       = 1'b0;
        end
      end
      RUN: begin
        if (core_iter_done_i) iter_cnt_d = iter_next;
        // The counter holds in the timeout cycle, so it reads TIMEOUT_CYC-1
        // after an abort.
        if (!(tmo_hit && !iter_complete) && (cycle_cnt_q != '1)) begin
          cycle_cnt_d = cycle_cnt_q + CycOne;
        end
        if (iter_complete) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          abort_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (soft_rst_ok) begin
      state_d     = IDLE;
      start_d     = 1'b0;
      abort_d     = (state_q == RUN);
      cycle_cnt_d = '0;
      iter_cnt_d  = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
    end

    irq_d = irq_en_d & (done_d | timeout_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      irq_en_q        <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      num_iter_q      <= '0;
      timeout_cyc_q   <= '0;
      cycle_cnt_q     <= '0;
      iter_cnt_q      <= '0;
      core_num_iter_q <= '0;
      start_q         <= 1'b0;
      abort_q         <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      irq_en_q        <= irq_en_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      num_iter_q      <= num_iter_d;
      timeout_cyc_q   <= timeout_cyc_d;
      cycle_cnt_q     <= cycle_cnt_d;
      iter_cnt_q      <= iter_cnt_d;
      core_num_iter_q <= core_num_iter_d;
      start_q         <= start_d;
      abort_q         <= abort_d;
      irq_q           <= irq_d;
    end
  end

  assign core_start_o    = start_q;
  assign core_abort_o    = abort_q;
  assign core_num_iter_o = core_num_iter_q;
  assign busy_o          = busy;
  assign irq_o           = irq_q;

endmodule
